// File: rtl/condicionador_pkg.sv
// Shared types and defaults for the input-conditioning stage.
// Optional long-press detection is enabled by CONDICIONADOR_LONG_PRESS_EN.
package condicionador_pkg;

    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        CONF_PRESS  = 2'd1,
        PRESSIONADO = 2'd2,
        CONF_SOLTA  = 2'd3
    } estado_t;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_LONG_CYCLES     = 256;
    localparam int CH_W                = 8;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/condicionador_entradas_sincronizador.sv
// Multi-flop synchronizer for a bus of independent slow signals.
// Resets asynchronously to a per-instance value.
module sincronizador #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_div,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    // Shift the raw value through the synchronizer chain.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= RST_VAL;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/condicionador_entradas.sv
// Synchronizes switches and button, debounces the button and emits a press pulse.
// Define CONDICIONADOR_LONG_PRESS_EN to enable the long_press output.
module condicionador_entradas
    import condicionador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic            clk_div,
    input  logic            rst,
    input  logic [CH_W-1:0] ch_raw,
    input  logic            botao_raw,
    output logic [CH_W-1:0] ch,
    output logic            botao,
    output logic            botao_nivel,
    output logic [CH_W-1:0] ch_cap,
    output logic            long_press
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("LONG_CYCLES must be >= 1");
    end

    logic    p_in;
    logic    p;
    estado_t estado;
    estado_t estado_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic    pulso;

    // Normalize the button so that pressed reads as 1 internally.
    assign p_in = BTN_ACTIVE_LOW ? ~botao_raw : botao_raw;

    sincronizador #(
        .WIDTH  (CH_W),
        .STAGES (SYNC_STAGES),
        .RST_VAL('0)
    ) u_sync_ch (
        .clk_div(clk_div),
        .rst    (rst),
        .d      (ch_raw),
        .q      (ch)
    );

    sincronizador #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b0)
    ) u_sync_btn (
        .clk_div(clk_div),
        .rst    (rst),
        .d      (p_in),
        .q      (p)
    );

    // Debounce next-state logic; a transition needs DEBOUNCE_CYCLES stable samples.
    always_comb begin
        estado_next = estado;
        cnt_next    = cnt;
        pulso       = 1'b0;
        unique case (estado)
            SOLTO: begin
                if (p) begin
                    estado_next = CONF_PRESS;
                    cnt_next    = CNT_ONE;
                end
            end
            CONF_PRESS: begin
                if (!p) begin
                    estado_next = SOLTO;
                    cnt_next    = '0;
                end else if (cnt == CNT_LAST) begin
                    estado_next = PRESSIONADO;
                    cnt_next    = '0;
                    pulso       = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            PRESSIONADO: begin
                if (!p) begin
                    estado_next = CONF_SOLTA;
                    cnt_next    = CNT_ONE;
                end
            end
            CONF_SOLTA: begin
                if (p) begin
                    estado_next = PRESSIONADO;
                    cnt_next    = '0;
                end else if (cnt == CNT_LAST) begin
                    estado_next = SOLTO;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                estado_next = SOLTO;
                cnt_next    = '0;
            end
        endcase
    end

    // State, counter and registered outputs; snapshot switches with the pulse.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            estado      <= SOLTO;
            cnt         <= '0;
            botao       <= 1'b0;
            botao_nivel <= 1'b0;
            ch_cap      <= '0;
        end else begin
            estado      <= estado_next;
            cnt         <= cnt_next;
            botao       <= pulso;
            botao_nivel <= (estado_next == PRESSIONADO) ||
                           (estado_next == CONF_SOLTA);
            if (pulso) begin
                ch_cap <= ch;
            end
        end
    end

`ifdef CONDICIONADOR_LONG_PRESS_EN
    localparam int LW = cnt_w(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] long_cnt;
    logic          long_q;

    // Count edges held in PRESSIONADO; fire once when the count reaches the limit.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            long_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (estado_next == SOLTO) begin
                long_cnt <= '0;
            end else if (estado == PRESSIONADO && long_cnt != LONG_MAX) begin
                long_cnt <= long_cnt + LW'(1);
                if (long_cnt == LONG_LAST) begin
                    long_q <= 1'b1;
                end
            end
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule
